lmsm_sequencer: RTL and testbench

Sequencer that expands one load-multiple or store-multiple (LM/SM) instruction into single-register micro-ops for the load/store unit. It issues one micro-op per accepted handshake, lowest set mask bit first. For each micro-op it generates the base/offset pair, rename destination tag, store-buffer index and ROB index. It sits between the LM/SM issue slot and the load/store unit's input port, and drives `is_LMSM=1` so the LSU suppresses Z-flag writes.

---
 rtl/lmsm_sequencer_if.sv | 45 ++++
 rtl/lmsm_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_lmsm_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lmsm_sequencer_if.sv
// LM/SM sequencer port bundle: the instruction-issue side (in_*) and the
// load/store-unit side (ls_*).
//
// Handshake rule, both sides: a transfer happens on a rising clock edge where
// valid && ready are both 1. The producer must not withdraw or change a
// payload while valid=1 and ready=0; ready may depend on valid.
//
// Modport master: the sequencer's view (it masters the LSU micro-op port and
// answers the issue slot). Modport slave: the surrounding pipeline's view.
interface lmsm_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_is_store;
  logic [7:0]  in_mask;
  logic [15:0] in_base;
  logic [55:0] in_dest_tags;
  logic [4:0]  in_sb_index;
  logic [6:0]  in_rob_index;

  logic        ls_valid;
  logic        ls_ready;
  logic        ls_load_store;
  logic [15:0] ls_base;
  logic [15:0] ls_offset;
  logic [6:0]  ls_dest;
  logic [2:0]  ls_arch_dest;
  logic [4:0]  ls_sb_index;
  logic [6:0]  ls_rob_index;
  logic        ls_is_lmsm;
  logic [15:0] ls_source_data;

  modport master (
    input  in_valid, in_is_store, in_mask, in_base, in_dest_tags,
           in_sb_index, in_rob_index, ls_ready,
    output in_ready, ls_valid, ls_load_store, ls_base, ls_offset, ls_dest,
           ls_arch_dest, ls_sb_index, ls_rob_index, ls_is_lmsm, ls_source_data
  );

  modport slave (
    output in_valid, in_is_store, in_mask, in_base, in_dest_tags,
           in_sb_index, in_rob_index, ls_ready,
    input  in_ready, ls_valid, ls_load_store, ls_base, ls_offset, ls_dest,
           ls_arch_dest, ls_sb_index, ls_rob_index, ls_is_lmsm, ls_source_data
  );
endinterface

// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer: expands one LM/SM instruction into single-register micro-ops
// for the load/store unit, lowest set mask bit first, one per accepted
// handshake. Zero-mask instructions complete immediately via empty_done.
//
// Optional feature: define LMSM_BACKTOBACK_EN to let a new instruction be
// accepted in the same cycle the final micro-op transfers (zero bubble).
module lmsm_sequencer #(
  parameter int OFFSET_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  lmsm_sequencer_if.master bus,
  output logic [2:0]       rf_rd_addr,
  input  logic [15:0]      rf_rd_data,
  output logic             empty_done,
  output logic [6:0]       empty_rob_index,
  output logic             busy,
  output logic             dbg_state_o
);

  typedef enum logic {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_e;

  localparam logic [15:0] STEP = 16'(OFFSET_STEP);

  state_e      state_q, state_d;
  logic [7:0]  rem_mask_q, rem_mask_d;
  logic [3:0]  k_q, k_d;
  logic        is_store_q, is_store_d;
  logic [15:0] base_q, base_d;
  logic [55:0] tags_q, tags_d;
  logic [4:0]  sb_q, sb_d;
  logic [6:0]  rob_q, rob_d;
  logic        empty_q, empty_d;
  logic [6:0]  empty_rob_q, empty_rob_d;

  logic [2:0]  cur_idx;
  logic [6:0]  cur_tag;
  logic [7:0]  mask_clr;
  logic        ls_valid_w;
  logic        fire;
  logic        last_xfer;
  logic        in_ready_w;
  logic        accept;

  // Priority-encode the lowest set bit of the remaining mask.
  always_comb begin
    cur_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rem_mask_q[i]) cur_idx = 3'(i);
    end
  end

  // Select the captured physical tag for the current register.
  always_comb begin
    cur_tag = 7'd0;
    for (int i = 0; i < 8; i++) begin
      if (cur_idx == 3'(i)) cur_tag = tags_q[7*i +: 7];
    end
  end

  // Handshake qualifiers; flush squashes both sides combinationally.
  always_comb begin
    mask_clr   = rem_mask_q & ~(8'b1 << cur_idx);
    ls_valid_w = (state_q == ST_ISSUE) && !flush;
    fire       = ls_valid_w && bus.ls_ready;
    last_xfer  = fire && (mask_clr == 8'd0);
`ifdef LMSM_BACKTOBACK_EN
    in_ready_w = !flush && ((state_q == ST_IDLE) || last_xfer);
`else
    in_ready_w = !flush && (state_q == ST_IDLE);
`endif
    accept     = bus.in_valid && in_ready_w;
  end

  // Next-state logic: flush wins, then transfer bookkeeping, then capture.
  always_comb begin
    state_d     = state_q;
    rem_mask_d  = rem_mask_q;
    k_d         = k_q;
    is_store_d  = is_store_q;
    base_d      = base_q;
    tags_d      = tags_q;
    sb_d        = sb_q;
    rob_d       = rob_q;
    empty_d     = 1'b0;
    empty_rob_d = empty_rob_q;
    if (flush) begin
      state_d    = ST_IDLE;
      rem_mask_d = 8'd0;
      k_d        = 4'd0;
    end else begin
      if (fire) begin
        rem_mask_d = mask_clr;
        k_d        = k_q + 4'd1;
        if (mask_clr == 8'd0) state_d = ST_IDLE;
      end
      // A capture in the final-transfer cycle overrides the bookkeeping above.
      if (accept) begin
        is_store_d = bus.in_is_store;
        base_d     = bus.in_base;
        tags_d     = bus.in_dest_tags;
        sb_d       = bus.in_sb_index;
        rob_d      = bus.in_rob_index;
        rem_mask_d = bus.in_mask;
        k_d        = 4'd0;
        if (bus.in_mask != 8'd0) begin
          state_d = ST_ISSUE;
        end else begin
          state_d     = ST_IDLE;
          empty_d     = 1'b1;
          empty_rob_d = bus.in_rob_index;
        end
      end
    end
  end

  // State and capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rem_mask_q  <= 8'd0;
      k_q         <= 4'd0;
      is_store_q  <= 1'b0;
      base_q      <= 16'd0;
      tags_q      <= 56'd0;
      sb_q        <= 5'd0;
      rob_q       <= 7'd0;
      empty_q     <= 1'b0;
      empty_rob_q <= 7'd0;
    end else begin
      state_q     <= state_d;
      rem_mask_q  <= rem_mask_d;
      k_q         <= k_d;
      is_store_q  <= is_store_d;
      base_q      <= base_d;
      tags_q      <= tags_d;
      sb_q        <= sb_d;
      rob_q       <= rob_d;
      empty_q     <= empty_d;
      empty_rob_q <= empty_rob_d;
    end
  end

  // Micro-op outputs: driven from registered state, forced to 0 when idle.
  always_comb begin
    bus.in_ready       = in_ready_w;
    bus.ls_valid       = ls_valid_w;
    bus.ls_load_store  = 1'b0;
    bus.ls_base        = 16'd0;
    bus.ls_offset      = 16'd0;
    bus.ls_dest        = 7'd0;
    bus.ls_arch_dest   = 3'd0;
    bus.ls_sb_index    = 5'd0;
    bus.ls_rob_index   = 7'd0;
    bus.ls_is_lmsm     = 1'b0;
    bus.ls_source_data = 16'd0;
    rf_rd_addr         = 3'd0;
    if (ls_valid_w) begin
      bus.ls_load_store  = is_store_q;
      bus.ls_base        = base_q;
      bus.ls_offset      = {12'd0, k_q} * STEP;
      bus.ls_dest        = cur_tag;
      bus.ls_arch_dest   = cur_idx;
      bus.ls_sb_index    = sb_q + {1'b0, k_q};
      bus.ls_rob_index   = rob_q + {3'd0, k_q};
      bus.ls_is_lmsm     = 1'b1;
      bus.ls_source_data = rf_rd_data;
      rf_rd_addr         = cur_idx;
    end
  end

  // Status outputs; a flush in the pulse cycle cancels the empty completion.
  always_comb begin
    empty_done      = empty_q && !flush;
    empty_rob_index = empty_done ? empty_rob_q : 7'd0;
    busy            = (state_q == ST_ISSUE);
    dbg_state_o     = (state_q == ST_ISSUE);
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed testbench for lmsm_sequencer. A queue-based model expands each
// accepted instruction into its expected micro-op list; a negedge compare
// process checks every output every cycle, and literal expectations pin the
// model on the key scenarios.
module tb_lmsm_sequencer;
  localparam int STEP = 1;
  localparam int W    = 55;
`ifdef LMSM_BACKTOBACK_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] rf_rd_data = 16'd0;
  logic [2:0]  rf_rd_addr;
  logic        empty_done;
  logic [6:0]  empty_rob_index;
  logic        busy;
  logic        dbg_state;

  lmsm_sequencer_if bus();

  lmsm_sequencer #(.OFFSET_STEP(STEP)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .bus             (bus),
    .rf_rd_addr      (rf_rd_addr),
    .rf_rd_data      (rf_rd_data),
    .empty_done      (empty_done),
    .empty_rob_index (empty_rob_index),
    .busy            (busy),
    .dbg_state_o     (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  // Packed micro-op: {store, arch[2:0], dest[6:0], base[15:0], offset[15:0], sb[4:0], rob[6:0]}
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  logic [15:0]  obs_src[$];
  int           obs_cyc[$];
  logic         m_empty = 1'b0;
  logic [6:0]   m_empty_rob = 7'd0;
  int           cyc = 0;
  int           valid_cycles = 0;
  int           empty_cnt = 0;
  logic [6:0]   last_empty_rob = 7'd0;
  int           n_vec = 0;
  int           n_bad = 0;

  function automatic logic [W-1:0] pack(input logic st, input logic [2:0] a,
                                        input logic [6:0] d, input logic [15:0] b,
                                        input logic [15:0] o, input logic [4:0] s,
                                        input logic [6:0] r);
    return {st, a, d, b, o, s, r};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expand one instruction: k-th set bit (ascending) gets offset k*STEP, sb+k, rob+k.
  task automatic model_load(input logic st, input logic [7:0] m, input logic [15:0] b,
                            input logic [55:0] tg, input logic [4:0] sb, input logic [6:0] rob);
    int k;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        exp_q.push_back(pack(st, 3'(i), tg[7*i +: 7], b, 16'(k * STEP),
                             sb + 5'(k), rob + 7'(k)));
        k++;
      end
    end
  endtask

  function automatic logic [W-1:0] dut_uop();
    return pack(bus.ls_load_store, bus.ls_arch_dest, bus.ls_dest, bus.ls_base,
                bus.ls_offset, bus.ls_sb_index, bus.ls_rob_index);
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic         e_valid, e_last, e_rdy, e_empty;
    logic [W-1:0] head;
    if (!rst_n) begin
      exp_q.delete();
      m_empty     = 1'b0;
      m_empty_rob = 7'd0;
    end else begin
      e_valid = (exp_q.size() != 0) && !flush;
      e_last  = e_valid && bus.ls_ready && (exp_q.size() == 1);
      e_rdy   = !flush && ((exp_q.size() == 0) || (BTB && e_last));
      e_empty = m_empty && !flush;
      check("ls_valid", 64'(bus.ls_valid), 64'(e_valid));
      check("in_ready", 64'(bus.in_ready), 64'(e_rdy));
      check("busy", 64'(busy), 64'(exp_q.size() != 0));
      check("empty_done", 64'(empty_done), 64'(e_empty));
      check("empty_rob_index", 64'(empty_rob_index), 64'(e_empty ? m_empty_rob : 7'd0));
      if (e_valid) begin
        head = exp_q[0];
        check("uop", 64'(dut_uop()), 64'(head));
        check("ls_is_lmsm", 64'(bus.ls_is_lmsm), 64'(1));
        check("rf_rd_addr", 64'(rf_rd_addr), 64'(head[53:51]));
        check("ls_source_data", 64'(bus.ls_source_data), 64'(rf_rd_data));
      end else begin
        check("uop_idle_zero", 64'(dut_uop()), 64'(0));
        check("ls_is_lmsm_idle", 64'(bus.ls_is_lmsm), 64'(0));
        check("rf_rd_addr_idle", 64'(rf_rd_addr), 64'(0));
        check("ls_source_idle", 64'(bus.ls_source_data), 64'(0));
      end
      // Observation log of what the DUT actually presented.
      if (bus.ls_valid) valid_cycles++;
      if (empty_done) begin
        empty_cnt++;
        last_empty_rob = empty_rob_index;
      end
      if (bus.ls_valid && bus.ls_ready) begin
        obs_q.push_back(dut_uop());
        obs_src.push_back(bus.ls_source_data);
        obs_cyc.push_back(cyc);
      end
      // Advance the model to the next cycle.
      m_empty = 1'b0;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (e_valid && bus.ls_ready) void'(exp_q.pop_front());
        if (bus.in_valid && e_rdy) begin
          if (bus.in_mask == 8'd0) begin
            m_empty     = 1'b1;
            m_empty_rob = bus.in_rob_index;
          end else begin
            model_load(bus.in_is_store, bus.in_mask, bus.in_base, bus.in_dest_tags,
                       bus.in_sb_index, bus.in_rob_index);
          end
        end
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic sync, input logic keep, input logic st,
                      input logic [7:0] m, input logic [15:0] b, input logic [55:0] tg,
                      input logic [4:0] sb, input logic [6:0] rob);
    logic done;
    done = 1'b0;
    if (sync) begin
      @(posedge clk);
      #1;
    end
    bus.in_valid     = 1'b1;
    bus.in_is_store  = st;
    bus.in_mask      = m;
    bus.in_base      = b;
    bus.in_dest_tags = tg;
    bus.in_sb_index  = sb;
    bus.in_rob_index = rob;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      #1;
      if (bus.in_ready) done = 1'b1;
    end
    check("accept_within_budget", 64'(done), 64'(1));
    @(posedge clk);
    #1;
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic wait_obs(input int target, input int budget);
    int c;
    c = 0;
    while (obs_q.size() < target && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("transfers_within_budget", 64'(obs_q.size() >= target), 64'(1));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int          m, v0, e0, gap;
    logic [55:0] tags;
    bus.in_valid     = 1'b0;
    bus.in_is_store  = 1'b0;
    bus.in_mask      = 8'd0;
    bus.in_base      = 16'd0;
    bus.in_dest_tags = 56'd0;
    bus.in_sb_index  = 5'd0;
    bus.in_rob_index = 7'd0;
    bus.ls_ready     = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ls_valid", 64'(bus.ls_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_empty_done", 64'(empty_done), 64'(0));
    check("rst_ls_rob_index", 64'(bus.ls_rob_index), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));

    // LM, no stall
    m = obs_q.size();
    tags = 56'd0;
    tags[14 +: 7] = 7'd10;
    tags[35 +: 7] = 7'd11;
    tags[49 +: 7] = 7'd12;
    send(1'b1, 1'b0, 1'b0, 8'b1010_0100, 16'h0100, tags, 5'd0, 7'd5);
    wait_obs(m + 3, 20);
    check("lm_uop0", 64'(obs_q[m]),   64'(pack(1'b0, 3'd2, 7'd10, 16'h0100, 16'd0, 5'd0, 7'd5)));
    check("lm_uop1", 64'(obs_q[m+1]), 64'(pack(1'b0, 3'd5, 7'd11, 16'h0100, 16'd1, 5'd1, 7'd6)));
    check("lm_uop2", 64'(obs_q[m+2]), 64'(pack(1'b0, 3'd7, 7'd12, 16'h0100, 16'd2, 5'd2, 7'd7)));
    check("lm_consecutive", 64'(obs_cyc[m+2] - obs_cyc[m]), 64'(2));
    repeat (2) @(negedge clk);

    // SM with two stall cycles and index wrap
    #1;
    bus.ls_ready = 1'b0;
    rf_rd_data   = 16'hBEEF;
    v0 = valid_cycles;
    m  = obs_q.size();
    send(1'b1, 1'b0, 1'b1, 8'h03, 16'h2000, 56'd0, 5'd31, 7'd127);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.ls_ready = 1'b1;
    wait_obs(m + 2, 10);
    check("sm_uop0", 64'(obs_q[m]),   64'(pack(1'b1, 3'd0, 7'd0, 16'h2000, 16'd0, 5'd31, 7'd127)));
    check("sm_uop1", 64'(obs_q[m+1]), 64'(pack(1'b1, 3'd1, 7'd0, 16'h2000, 16'd1, 5'd0, 7'd0)));
    check("sm_source", 64'(obs_src[m]), 64'(16'hBEEF));
    check("sm_valid_cycles", 64'(valid_cycles - v0), 64'(4));
    repeat (2) @(negedge clk);

    // Zero mask
    e0 = empty_cnt;
    v0 = valid_cycles;
    send(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 56'd0, 5'd0, 7'd9);
    repeat (3) @(negedge clk);
    #1;
    check("zero_empty_pulses", 64'(empty_cnt - e0), 64'(1));
    check("zero_empty_rob", 64'(last_empty_rob), 64'(9));
    check("zero_no_uops", 64'(valid_cycles - v0), 64'(0));

    // Flush after the third transfer of a full mask
    m = obs_q.size();
    send(1'b1, 1'b0, 1'b0, 8'hFF, 16'h0040, 56'h0123_4567_89AB_CD, 5'd3, 7'd40);
    wait_obs(m + 3, 20);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    #1;
    check("flush_ls_valid", 64'(bus.ls_valid), 64'(0));
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    #1;
    check("flush_in_ready", 64'(bus.in_ready), 64'(1));
    check("flush_busy", 64'(busy), 64'(0));
    repeat (4) @(negedge clk);
    check("flush_transfer_count", 64'(obs_q.size() - m), 64'(3));

    // Asynchronous reset mid-sequence
    send(1'b1, 1'b0, 1'b0, 8'hFF, 16'h0300, 56'd0, 5'd0, 7'd60);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_ls_valid", 64'(bus.ls_valid), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_ls_offset", 64'(bus.ls_offset), 64'(0));
    check("arst_ls_rob", 64'(bus.ls_rob_index), 64'(0));
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("arst_in_ready", 64'(bus.in_ready), 64'(1));
    check("arst_busy_after", 64'(busy), 64'(0));

    // Back-to-back: in_valid held across two single-bit instructions
    m = obs_q.size();
    send(1'b1, 1'b1, 1'b0, 8'h01, 16'h0000, 56'd0, 5'd0, 7'd20);
    send(1'b0, 1'b0, 1'b0, 8'h02, 16'h0000, 56'd0, 5'd1, 7'd30);
    wait_obs(m + 2, 20);
    gap = obs_cyc[m+1] - obs_cyc[m];
    check("b2b_arch_first", 64'(obs_q[m][53:51]), 64'(0));
    check("b2b_arch_second", 64'(obs_q[m+1][53:51]), 64'(1));
    check("b2b_gap", 64'(gap), 64'(BTB ? 1 : 2));

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
